seq_sub16: RTL and testbench
============================

// Module: seq_sub16
// PURPOSE
//   Multi-cycle two's-complement subtractor: d = a - b - bin. It is the inverse-operation
//   companion to the adder datapath and is used where area matters more than latency.
//   Processes DIGIT bits per clock, LSB digit first, with a borrow rippled between cycles.
//   Uses a start/busy/done handshake and keeps results held until the next accepted start.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of DIGIT
//   DIGIT  4   bits subtracted per cycle; latency N = WIDTH/DIGIT cycles
// PORTS
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a      in   WIDTH  minuend, sampled on the accepting edge
//   b      in   WIDTH  subtrahend, sampled on the accepting edge
//   bin    in   1      borrow-in, sampled on the accepting edge
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; d/bout/ovf are valid from this cycle on
//   d      out  WIDTH  difference
//   bout   out  1      final borrow; 1 iff unsigned a < b + bin
//   ovf    out  1      signed overflow: a[MSB]!=b[MSB] && d[MSB]!=a[MSB]
//   z      out  1      zero flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE. busy, done, d, bout, ovf and z are all 0.
//     Operand registers, digit counter and borrow register are cleared.
//   - FSM: IDLE --start--> RUN --(cnt==N-1)--> DONE --start--> RUN; DONE --!start--> IDLE.
//   - Accepting edge (start=1 in IDLE or DONE):
//     - latch a, b and bin; borrow reg <= bin; cnt <= 0.
//     - clear d, bout, ovf and z.
//   - RUN: each edge processes digit k=cnt:
//     - {br, dig} = a[k] - b[k] - borrow, computed as a (DIGIT+1)-bit subtract.
//     - result digit k <= dig; borrow <= br; cnt <= cnt+1.
//     - Operands are shifted right by DIGIT, or indexed; either is acceptable.
//   - Latency: done=1 exactly N cycles after the accepting edge (N=4 by default).
//     busy=1 for the N cycles before that.
//   - DONE (one cycle): done=1, busy=0, bout = final borrow, ovf per formula.
//     Outputs hold until the next accepting edge.
//   - start while in RUN is ignored; no queuing and no abort.
//   - Back-to-back: start high during DONE is accepted. done drops, busy rises the next cycle.
//   - Wrap-around: the result is modulo 2^WIDTH (0x0000-0x0001 = 0xFFFF, bout=1).
//   - Reset mid-RUN: immediately returns to the reset state and the partial result is discarded.
//   - Inputs a, b and bin may change freely after the accepting edge without affecting the result.
// CONFIGURATION
//   SEQ_SUB_ZFLAG_EN
//     - defined: z = (d == 0). z is registered and updated in the DONE cycle with the other
//       flags; it is cleared on reset and on an accepting edge.
//     - undefined: z is tied to constant 0 and no zero-detect logic is built.
// TESTING
//   1. a=0x1234, b=0x0234, bin=0, start pulse -> done 4 cycles later: d=0x1000, bout=0, ovf=0, z=0.
//   2. a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0. Then a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1.
//   3. a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1, ovf=0.
//      Same operands with bin=0 -> d=0x0000, z=1 with SEQ_SUB_ZFLAG_EN and z=0 without it.
//   4. Send start with 0x0010-0x0001, then hold start high in RUN with other operands
//      -> request ignored, result d=0x000F. A start in the DONE cycle runs the new op, busy next cycle.
//   5. Pull rst_n low 2 cycles into RUN -> busy, done, d and flags are 0 immediately.
//      A new start after release gives a correct result with N-cycle latency.
//   6. Random a, b, bin, 1000 ops, with DIGIT=4 and DIGIT=1 (N=16) -> d, bout and ovf match the reference model.
//      done is seen exactly once per op.

Source files
------------

// File: rtl/seq_sub16.sv
// -----------------------------------------------------------------------------
// seq_sub16 : multi-cycle two's-complement subtractor, d = a - b - bin
//
// The operands are consumed DIGIT bits per clock, least significant digit
// first, with the borrow carried from one cycle to the next. An operation takes
// N = WIDTH/DIGIT cycles. The module trades latency for a narrow
// (DIGIT+1)-bit subtract stage.
//
// Handshake
//   A start request is accepted in IDLE or DONE. On the accepting edge the
//   operands and the borrow-in are latched, and the previous result and flags
//   are cleared. busy is high for the N RUN cycles. done pulses for one cycle,
//   and d/bout/ovf/z hold their values until the next accepted start. A start
//   that arrives during RUN is ignored.
//
// Parameters
//   WIDTH  operand/result width (default 16). It must be a multiple of DIGIT,
//          and DIGIT must be less than WIDTH.
//   DIGIT  bits processed per clock (default 4)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request
//   a      in   WIDTH  minuend, sampled on the accepting edge
//   b      in   WIDTH  subtrahend, sampled on the accepting edge
//   bin    in   1      borrow-in, sampled on the accepting edge
//   busy   out  1      high while the operation is running
//   done   out  1      one-cycle completion pulse
//   d      out  WIDTH  difference, modulo 2^WIDTH
//   bout   out  1      final borrow (unsigned a < b + bin)
//   ovf    out  1      signed overflow
//   z      out  1      zero flag
//
// Configuration macro
//   SEQ_SUB_ZFLAG_EN : when defined, z is a registered (d == 0) flag. When it
//                      is undefined, z is tied low and no zero detect is built.
// -----------------------------------------------------------------------------
module seq_sub16 #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             z
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // One digit of the subtraction. The top bit of the (DIGIT+1)-bit result
    // is the borrow out of this digit.
    function automatic logic [DIGIT:0] sub_digit(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             brw
    );
        sub_digit = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, brw};
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_a;          // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0]   r_b;          // subtrahend, shifted right each RUN cycle
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;        // partial result, filled from the top
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [DIGIT:0]     w_diff;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_a_msb;
    logic               w_b_msb;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == CNT_W'(N - 1));

    // The current digit always sits in the low DIGIT bits of the shifted operands.
    assign w_diff    = sub_digit(r_a[DIGIT-1:0], r_b[DIGIT-1:0], r_borrow);
    assign w_acc_nxt = {w_diff[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};

    // On the final digit, the low bits of the shifted operands hold the
    // original top digit. Their MSBs are therefore the operand sign bits.
    assign w_a_msb = r_a[DIGIT-1];
    assign w_b_msb = r_b[DIGIT-1];

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, with busy/done registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Operand capture, digit-serial subtraction, and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_d      <= {WIDTH{1'b0}};
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_d      <= {WIDTH{1'b0}};
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_run) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_borrow <= w_diff[DIGIT];
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= w_acc_nxt;
            // The visible result changes only once, when the last digit lands.
            if (w_last) begin
                r_d    <= w_acc_nxt;
                r_bout <= w_diff[DIGIT];
                r_ovf  <= (w_a_msb != w_b_msb) && (w_diff[DIGIT-1] != w_a_msb);
            end else begin
                r_d    <= r_d;
                r_bout <= r_bout;
                r_ovf  <= r_ovf;
            end
        end else begin
            r_a      <= r_a;
            r_b      <= r_b;
            r_borrow <= r_borrow;
            r_cnt    <= r_cnt;
            r_acc    <= r_acc;
            r_d      <= r_d;
            r_bout   <= r_bout;
            r_ovf    <= r_ovf;
        end
    end

`ifdef SEQ_SUB_ZFLAG_EN
    logic r_z;

    // Zero flag, updated together with the other flags on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else if (w_accept) begin
            r_z <= 1'b0;
        end else if (w_last) begin
            r_z <= (w_acc_nxt == {WIDTH{1'b0}});
        end else begin
            r_z <= r_z;
        end
    end

    assign z = r_z;
`else
    assign z = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_sub16.sv
module tb_seq_sub16;

    logic        clk;
    logic        rst_n;
    logic        start_drv;
    logic        sel1;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;

    logic        busy4, done4, bout4, ovf4, z4;
    logic [15:0] d4;
    logic        busy1, done1, bout1, ovf1, z1;
    logic [15:0] d1;

    logic        start4, start1;
    logic        w_busy, w_done, w_bout, w_ovf, w_z;
    logic [15:0] w_d;

    int checks;
    int failures;

    assign start4 = start_drv & ~sel1;
    assign start1 = start_drv & sel1;
    assign w_busy = sel1 ? busy1 : busy4;
    assign w_done = sel1 ? done1 : done4;
    assign w_d    = sel1 ? d1    : d4;
    assign w_bout = sel1 ? bout1 : bout4;
    assign w_ovf  = sel1 ? ovf1  : ovf4;
    assign w_z    = sel1 ? z1    : z4;

    seq_sub16 #(.WIDTH(16), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4), .z(z4)
    );

    seq_sub16 #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1), .z(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model computed directly from the arithmetic definition.
    function automatic void ref_sub(input logic [15:0] ra, input logic [15:0] rb, input logic rbin,
                                    output logic [15:0] rd, output logic rbout,
                                    output logic rovf, output logic rz);
        int signed full;
        full  = int'(ra) - int'(rb) - int'(rbin);
        rd    = 16'(full);
        rbout = (full < 0);
        rovf  = (ra[15] != rb[15]) && (rd[15] != ra[15]);
`ifdef SEQ_SUB_ZFLAG_EN
        rz    = (rd == 16'h0000);
`else
        rz    = 1'b0;
`endif
    endfunction

    // Drives one operation and records what the selected DUT showed. It
    // performs no checks of its own.
    task automatic exec_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tbin,
                           input int n, output int lat, output int ndone, output int busy_err,
                           output logic [15:0] od, output logic ob, output logic oo, output logic oz);
        lat = -1; ndone = 0; busy_err = 0; od = 16'h0; ob = 1'b0; oo = 1'b0; oz = 1'b0;
        @(negedge clk);
        a = ta; b = tbv; bin = tbin; start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        for (int k = 0; k <= n + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (w_done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; od = w_d; ob = w_bout; oo = w_ovf; oz = w_z;
                end
            end
            if (w_busy !== (k < n)) busy_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_drv = 1'b0; sel1 = 1'b0; a = 16'h0; b = 16'h0; bin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy4, done4, d4, bout4, ovf4, z4} !== 21'h0) begin
            failures++;
            $display("FAIL reset_dut4 got=%h exp=0", {busy4, done4, d4, bout4, ovf4, z4});
        end
        checks++;
        if ({busy1, done1, d1, bout1, ovf1, z1} !== 21'h0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=0", {busy1, done1, d1, bout1, ovf1, z1});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h0005};
        logic [15:0] tb_[5] = '{16'h0234, 16'h0001, 16'h0001, 16'h0005, 16'h0005};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ed [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0000};
        logic        eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat, nd, be;
        logic [15:0] od;
        logic ob, oo, oz, ez;
        sel1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
`ifdef SEQ_SUB_ZFLAG_EN
            ez = (ed[i] == 16'h0000);
`else
            ez = 1'b0;
`endif
            exec_op(ta[i], tb_[i], tc[i], 4, lat, nd, be, od, ob, oo, oz);
            checks++;
            if (lat !== 4) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
            checks++;
            if (nd !== 1) begin failures++; $display("FAIL dir%0d_done_count got=%0d exp=1", i, nd); end
            checks++;
            if (be !== 0) begin failures++; $display("FAIL dir%0d_busy got=%0d bad cycles exp=0", i, be); end
            checks++;
            if ({od, ob, oo, oz} !== {ed[i], eb[i], eo[i], ez}) begin
                failures++;
                $display("FAIL dir%0d_result got d=%h bout=%b ovf=%b z=%b exp d=%h bout=%b ovf=%b z=%b",
                         i, od, ob, oo, oz, ed[i], eb[i], eo[i], ez);
            end
            checks++;
            if ({d4, bout4, ovf4, z4} !== {ed[i], eb[i], eo[i], ez}) begin
                failures++;
                $display("FAIL dir%0d_hold got d=%h exp d=%h", i, d4, ed[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int kd;
        logic [15:0] ed;
        logic eb, eo, ez;
        sel1 = 1'b0;
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; bin = 1'b0; start_drv = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h1234;   // start stays high through RUN
        kd = -1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (done4 === 1'b1) begin kd = k; break; end
        end
        checks++;
        if (kd !== 4) begin failures++; $display("FAIL ign_latency got=%0d exp=4", kd); end
        checks++;
        if ({d4, bout4} !== {16'h000F, 1'b0}) begin
            failures++; $display("FAIL ign_result got d=%h bout=%b exp d=000f bout=0", d4, bout4);
        end
        @(negedge clk);               // start was high in DONE, so it is accepted
        checks++;
        if ({busy4, done4, d4} !== {1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b done=%b d=%h exp busy=1 done=0 d=0000", busy4, done4, d4);
        end
        start_drv = 1'b0;
        ref_sub(16'hFFFF, 16'h1234, 1'b0, ed, eb, eo, ez);
        kd = -1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin kd = k; break; end
        end
        checks++;
        if (kd !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", kd); end
        checks++;
        if ({d4, bout4, ovf4, z4} !== {ed, eb, eo, ez}) begin
            failures++; $display("FAIL b2b_result got d=%h exp d=%h", d4, ed);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, nd, be;
        logic [15:0] od, ed, ra, rb;
        logic ob, oo, oz, eb, eo, ez, rc;
        sel1 = 1'b0;
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; bin = 1'b1; start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy4 !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy4); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, d4, bout4, ovf4, z4} !== 21'h0) begin
            failures++;
            $display("FAIL rst_mid_run got=%h exp=0", {busy4, done4, d4, bout4, ovf4, z4});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        ref_sub(ra, rb, rc, ed, eb, eo, ez);
        exec_op(ra, rb, rc, 4, lat, nd, be, od, ob, oo, oz);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL rst_after_latency got=%0d exp=4", lat); end
        checks++;
        if ({od, ob, oo, oz} !== {ed, eb, eo, ez}) begin
            failures++; $display("FAIL rst_after_result got d=%h exp d=%h", od, ed);
        end
    endtask

    task automatic test_random(input int n, input int ops);
        int lat, nd, be;
        logic [15:0] od, ed, ra, rb;
        logic ob, oo, oz, eb, eo, ez, rc;
        sel1 = (n == 16);
        for (int i = 0; i < ops; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if (i % 50 == 0) rb = ra;                 // exercise zero and all-ones results
            if (i % 77 == 1) begin ra = 16'h8000; rb = 16'h7FFF; end
            ref_sub(ra, rb, rc, ed, eb, eo, ez);
            exec_op(ra, rb, rc, n, lat, nd, be, od, ob, oo, oz);
            checks++;
            if (lat !== n || nd !== 1 || be !== 0) begin
                failures++;
                $display("FAIL rnd_n%0d_timing op=%0d got lat=%0d dones=%0d busyerr=%0d exp lat=%0d dones=1 busyerr=0",
                         n, i, lat, nd, be, n);
            end
            checks++;
            if ({od, ob, oo, oz} !== {ed, eb, eo, ez}) begin
                failures++;
                $display("FAIL rnd_n%0d_result op=%0d a=%h b=%h bin=%b got d=%h bout=%b ovf=%b z=%b exp d=%h bout=%b ovf=%b z=%b",
                         n, i, ra, rb, rc, od, ob, oo, oz, ed, eb, eo, ez);
            end
        end
        sel1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random(4, 1000);
        test_random(16, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
